// File: rtl/divu_hilo_pkg.sv
// Shared funct-code constants and FSM state encoding for the ALU control
// path and the HI/LO unsigned-divide datapath.
package divu_hilo_pkg;

   localparam logic [5:0] FN_MFHI = 6'b010000;
   localparam logic [5:0] FN_MTHI = 6'b010001;
   localparam logic [5:0] FN_MFLO = 6'b010010;
   localparam logic [5:0] FN_MTLO = 6'b010011;
   localparam logic [5:0] FN_DIVU = 6'b011011;

   localparam int unsigned DIV_STEPS = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/divu_hilo_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when the result stays non-negative.
module div_step (
   input  logic [32:0] i_rem,
   input  logic        i_bit,
   input  logic [31:0] i_divisor,
   output logic [32:0] o_rem,
   output logic        o_qbit
);

   logic [32:0] w_shift;
   logic [32:0] w_div_ext;
   logic        w_ge;

   assign w_shift   = {i_rem[31:0], i_bit};
   assign w_div_ext = {1'b0, i_divisor};

   // A set bit 32 on the incoming remainder means the shifted value already
   // exceeds any divisor; the 33-bit modular subtraction still yields the
   // correct (sub-divisor) remainder.
   assign w_ge   = i_rem[32] | (w_shift >= w_div_ext);
   assign o_qbit = w_ge;
   assign o_rem  = w_ge ? (w_shift - w_div_ext) : w_shift;

endmodule

// File: rtl/divu_hilo.sv
// HI/LO register file with a 32-step iterative unsigned divider (DIVU) and
// MFHI/MTHI/MFLO/MTLO access.
module divu_hilo
   import divu_hilo_pkg::*;
#(
   parameter logic [5:0] DIVU = FN_DIVU,
   parameter logic [5:0] MFHI = FN_MFHI,
   parameter logic [5:0] MTHI = FN_MTHI,
   parameter logic [5:0] MFLO = FN_MFLO,
   parameter logic [5:0] MTLO = FN_MTLO
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] dataA,
   input  logic [31:0] dataB,
   input  logic [5:0]  Signal,
   input  logic        valid,
   output logic [31:0] dataOut,
   output logic        busy,
   output logic        done,
   output logic        div_zero
);

   state_t      r_state;
   state_t      w_next;
   logic [5:0]  r_cnt;
   logic [32:0] r_rem;
   logic [31:0] r_quo;
   logic [31:0] r_divisor;
   logic [31:0] r_hi;
   logic [31:0] r_lo;
   logic [31:0] r_dout;

   logic        w_cmd_divu;
   logic        w_cmd_mfhi;
   logic        w_cmd_mthi;
   logic        w_cmd_mflo;
   logic        w_cmd_mtlo;
   logic        w_last;
   logic [32:0] w_rem_nxt;
   logic        w_qbit;
   logic [31:0] w_quo_nxt;

   assign w_cmd_divu = valid && (Signal == DIVU);
   assign w_cmd_mfhi = valid && (Signal == MFHI);
   assign w_cmd_mthi = valid && (Signal == MTHI);
   assign w_cmd_mflo = valid && (Signal == MFLO);
   assign w_cmd_mtlo = valid && (Signal == MTLO);

   assign w_last = (r_cnt == 6'(DIV_STEPS - 1));

   div_step u_step (
      .i_rem     (r_rem),
      .i_bit     (r_quo[31]),
      .i_divisor (r_divisor),
      .o_rem     (w_rem_nxt),
      .o_qbit    (w_qbit)
   );

   // r_quo starts as the dividend; quotient bits shift in from the right
   // as dividend bits leave from the left.
   assign w_quo_nxt = {r_quo[30:0], w_qbit};

   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (w_cmd_divu) w_next = ST_RUN;
         ST_RUN:  if (w_last)     w_next = ST_DONE;
         ST_DONE: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt     <= '0;
         r_rem     <= '0;
         r_quo     <= '0;
         r_divisor <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_dout    <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_cmd_divu) begin
                  r_quo     <= dataA;
                  r_divisor <= dataB;
                  r_rem     <= '0;
                  r_cnt     <= '0;
               end
               if (w_cmd_mthi) r_hi <= dataA;
               if (w_cmd_mtlo) r_lo <= dataA;
            end
            ST_RUN: begin
               r_rem <= w_rem_nxt;
               r_quo <= w_quo_nxt;
               r_cnt <= r_cnt + 6'd1;
               if (w_last) begin
                  r_lo <= w_quo_nxt;
                  r_hi <= w_rem_nxt[31:0];
               end
            end
            default: ;
         endcase
         if (w_cmd_mfhi)      r_dout <= r_hi;
         else if (w_cmd_mflo) r_dout <= r_lo;
      end
   end

   assign dataOut  = r_dout;
   assign busy     = (r_state == ST_RUN);
   assign done     = (r_state == ST_DONE);
   assign div_zero = (r_state == ST_DONE) && (r_divisor == '0);

endmodule
